// File: rtl/zbt_arbiter.sv
// Three-port ZBT SRAM arbiter: fixed-priority display port with a starvation
// guard, round-robin between the two low ports, and read-data return routing.
module zbt_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int READ_LAT     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_rvalid,
  input  logic              p2_req,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic              p2_ack,
  output logic              p2_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_read
);

  typedef struct packed {
    logic       vld;
    logic [1:0] port;
  } tag_t;

  // Stage 0 is aligned with mem_addr; the word for it arrives READ_LAT cycles on.
  localparam int STAGES = READ_LAT;

  logic [2:0]             req, ack, lo_ack;
  logic [2:0][ADDR_W-1:0] p_addr;
  logic [2:0][DATA_W-1:0] p_wdata;
  logic [2:0]             p_we;
  logic [1:0]             sel;
  logic                   lo_pend, mask;

  logic                   rr_q, rr_d;
  logic [7:0]             starve_q, starve_d;
  tag_t [STAGES:0]        tag_q, tag_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_write_q, mem_write_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [2:0]             rvalid_q, rvalid_d;

  assign req     = {p2_req, p1_req, p0_req};
  assign p_addr  = {p2_addr, p1_addr, p0_addr};
  assign p_wdata = {p2_wdata, p1_wdata, p0_wdata};
  assign p_we    = {p2_we, p1_we, p0_we};

  // Grant decision: depends only on requests, rr and starve.
  always_comb begin
    ack     = 3'b000;
    lo_ack  = 3'b000;
    lo_pend = req[1] | req[2];
    if (rr_q) lo_ack = req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000);
    else      lo_ack = req[2] ? 3'b100 : (req[1] ? 3'b010 : 3'b000);
    mask = lo_pend && (starve_q == 8'(STARVE_LIMIT));
    if (reset)        ack = 3'b000;
    else if (mask)    ack = lo_ack;
    else if (req[0])  ack = 3'b001;
    else if (lo_pend) ack = lo_ack;
  end

  assign sel = ack[2] ? 2'd2 : (ack[1] ? 2'd1 : 2'd0);

  always_comb begin
    rr_d        = rr_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = mem_write_q;
    mem_wr_d    = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 3'b000;
    tag_d[0]    = '0;
    for (int k = 1; k <= STAGES; k++) tag_d[k] = tag_q[k-1];

    if (|ack) begin
      mem_addr_d  = p_addr[sel];
      mem_write_d = p_wdata[sel];
      mem_wr_d    = p_we[sel];
      tag_d[0]    = '{vld: ~p_we[sel], port: sel};
    end

    if (ack[1] | ack[2])                              starve_d = 8'd0;
    else if (ack[0] && lo_pend && starve_q != 8'hFF)  starve_d = starve_q + 8'd1;

    if (ack[1])      rr_d = 1'b0;
    else if (ack[2]) rr_d = 1'b1;

    if (tag_q[STAGES].vld) begin
      rdata_d = mem_read;
      case (tag_q[STAGES].port)
        2'd0:    rvalid_d = 3'b001;
        2'd1:    rvalid_d = 3'b010;
        2'd2:    rvalid_d = 3'b100;
        default: rvalid_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q        <= 1'b1;
      starve_q    <= 8'd0;
      tag_q       <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= '0;
      mem_wr_q    <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 3'b000;
    end else begin
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      tag_q       <= tag_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_wr_q    <= mem_wr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign p0_ack    = ack[0];
  assign p1_ack    = ack[1];
  assign p2_ack    = ack[2];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p2_rvalid = rvalid_q[2];
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_write = mem_write_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_zbt_arbiter.sv
// Directed bench for zbt_arbiter: writes, read return, ordering, round-robin,
// starvation guard and asynchronous reset with reads in flight.
module tb_zbt_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;

  logic clock, reset;
  logic p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr, p2_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p2_wdata;
  logic p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid;
  logic [DATA_W-1:0] rdata, mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_wr;

  int checks = 0;
  int errors = 0;

  zbt_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ack(p2_ack), .p2_rvalid(p2_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wr(mem_wr),
    .mem_read(mem_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bank model: word for an address appears two cycles after it is on mem_addr.
  logic [ADDR_W-1:0] a1, a2;
  always @(posedge clock) begin
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_read = {20'hABCDE, a2[15:0]};

  wire [2:0] acks = {p2_ack, p1_ack, p0_ack};
  wire [2:0] rvs  = {p2_rvalid, p1_rvalid, p0_rvalid};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {p0_req, p0_we, p1_req, p1_we, p2_req, p2_we} = '0;
    p0_addr = '0; p1_addr = '0; p2_addr = '0;
    p0_wdata = '0; p1_wdata = '0; p2_wdata = '0;
    p0_req = 1'b1;
    #3;
    chk("rst_ack", acks, 3'b000);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvs, 3'b000);
    p0_req = 1'b0;
    repeat (2) @(posedge clock);
    #5 reset = 1'b0;

    // Single write on port 1
    tick;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 19'h00010; p1_wdata = 36'h123456789;
    #2 chk("wr_ack", acks, 3'b010);
    tick; p1_req = 1'b0;
    #2 chk("wr_addr", mem_addr, 19'h00010);
    chk("wr_data", mem_write, 36'h123456789);
    chk("wr_we", mem_wr, 1'b1);
    tick;
    #2 chk("wr_we_clear", mem_wr, 1'b0);

    // Single read on port 0: rvalid exactly four cycles after ack
    tick;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 19'd5;
    #2 chk("rd_ack", acks, 3'b001);
    tick; p0_req = 1'b0;
    #2 chk("rd_rv_t1", rvs, 3'b000);
    chk("rd_mem_wr", mem_wr, 1'b0);
    tick; #2 chk("rd_rv_t2", rvs, 3'b000);
    tick; #2 chk("rd_rv_t3", rvs, 3'b000);
    tick; #2 chk("rd_rv_t4", rvs, 3'b001);
    chk("rd_data", rdata, 36'hABCDE0005);
    tick; #2 chk("rd_rv_t5", rvs, 3'b000);

    // Mixed read ordering across ports
    tick;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 19'd1;
    #2 chk("mix_ack0", acks, 3'b001);
    tick; p0_req = 1'b0;
    p2_req = 1'b1; p2_we = 1'b0; p2_addr = 19'd2;
    #2 chk("mix_ack2", acks, 3'b100);
    tick; p2_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 19'd3;
    #2 chk("mix_ack1", acks, 3'b010);
    tick; p1_req = 1'b0;
    #2 chk("mix_rv_idle", rvs, 3'b000);
    tick; #2 chk("mix_rv0", rvs, 3'b001);
    chk("mix_d0", rdata, 36'hABCDE0001);
    tick; #2 chk("mix_rv2", rvs, 3'b100);
    chk("mix_d2", rdata, 36'hABCDE0002);
    tick; #2 chk("mix_rv1", rvs, 3'b010);
    chk("mix_d1", rdata, 36'hABCDE0003);
    tick; #2 chk("mix_rv_end", rvs, 3'b000);

    // Starvation guard with limit 4: 0,0,0,0,1 repeating
    tick;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 19'd20; p0_wdata = 36'h0AAAA;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 19'd21; p1_wdata = 36'h0BBBB;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick;
      #2 chk($sformatf("starve_ack%0d", i), acks, (i % 5 == 4) ? 3'b010 : 3'b001);
      if (i == 4) chk("starve_at_limit", dut.starve_q, 8'd4);
      if (i == 5) chk("starve_cleared", dut.starve_q, 8'd0);
    end
    tick; p0_req = 1'b0; p1_req = 1'b0;

    // Reset with two reads and a write in flight; rr left pointing at port 2
    tick;
    p2_req = 1'b1; p2_we = 1'b0; p2_addr = 19'd8;
    #2 chk("rst_op_ack2", acks, 3'b100);
    tick; p2_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 19'd7;
    #2 chk("rst_op_ack1", acks, 3'b010);
    tick; p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 19'd9; p0_wdata = 36'h0CCCC;
    #2 chk("rst_op_ack0", acks, 3'b001);
    tick; p0_req = 1'b0;
    #2 chk("rst_op_pre_wr", mem_wr, 1'b1);
    reset = 1'b1;
    p1_req = 1'b1; p2_req = 1'b1;
    #1 chk("rst_op_wr", mem_wr, 1'b0);
    chk("rst_op_addr", mem_addr, 0);
    chk("rst_op_rv", rvs, 3'b000);
    chk("rst_op_ack", acks, 3'b000);
    p1_req = 1'b0; p2_req = 1'b0;
    tick; tick;
    #4 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      #2 chk($sformatf("rst_op_norv%0d", i), rvs, 3'b000);
    end

    // Round-robin between ports 1 and 2, p0 idle
    tick;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 19'd30;
    p2_req = 1'b1; p2_we = 1'b1; p2_addr = 19'd31;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick;
      #2 chk($sformatf("rr_ack%0d", i), acks, (i % 2 == 0) ? 3'b010 : 3'b100);
    end
    tick; p1_req = 1'b0; p2_req = 1'b0;
    #2 chk("idle_ack", acks, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zbt_arbiter.md
# zbt_arbiter

Three-port arbiter that shares one ZBT SRAM bank between the display reader, the capture writer and the image processor. It sits between those clients and the bank's address/data/write-enable signals, which are the same signals a test-pattern writer drives. It issues at most one access per clock, at full bandwidth. It also routes returning read data back to the port that requested it.

## Interface
Parameters:
- ADDR_W, 19, word address width (`LOG_ADDR`)
- DATA_W, 36, memory word width (`LOG_MEM`)
- READ_LAT, 2, cycles from address on `mem_addr` to matching word on `mem_read`
- STARVE_LIMIT, 8, consecutive port-0 grants allowed while port 1/2 waits (range 1..255)

Ports:
- clock  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- pN_req  in  1  port N (N=0,1,2) request; hold it with addr/we/wdata stable until pN_ack
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data, ignored for reads
- pN_ack  out  1  combinational; request accepted at the end of this cycle
- pN_rvalid  out  1  registered; rdata holds port N's read word this cycle
- rdata  out  DATA_W  registered copy of `mem_read`, shared by all ports
- mem_addr  out  ADDR_W  registered address to the ZBT bank
- mem_write  out  DATA_W  registered write data, aligned with mem_addr; the ZBT driver applies the bank's data delay
- mem_wr  out  1  registered write enable
- mem_read  in  DATA_W  read data from the bank

## Operation
- Priority:
  - Port 0 (display) has fixed highest priority.
  - Ports 1 and 2 share the remaining slots round-robin, tracked by a 1-bit pointer `rr`.
  - `rr` = 1 means port 1 is preferred; after reset `rr` = 1.
  - `rr` moves to the other low port after each low-port grant. It does not move when no low port is granted.
- Starvation guard:
  - 8-bit counter `starve` increments on every cycle where port 0 is granted while p1_req or p2_req is high.
  - `starve` clears on any low-port grant.
  - When `starve` equals STARVE_LIMIT, port 0 is masked for that cycle. The `rr`-preferred pending low port is granted instead, or the other low port if only it is pending.
- Selection, each cycle:
  - If the starve mask applies, grant a low port.
  - Otherwise, if p0_req is high, grant port 0.
  - Otherwise grant the `rr`-preferred low port if it requests, else the other one.
  - Otherwise no grant.
  - Exactly one pN_ack, or none, is high.
- Issue: on a grant edge, mem_addr ← pN_addr, mem_write ← pN_wdata, mem_wr ← pN_we. With no grant, mem_wr ← 0 and mem_addr/mem_write hold their values.
- Read tracking:
  - A shift register of depth READ_LAT carries a {valid, port[1:0]} tag for each issued read.
  - Writes and idle cycles insert invalid tags.
  - Tag exit registers rdata ← mem_read and raises the matching pN_rvalid for one cycle.
- Reset (asynchronous, at any time):
  - mem_addr = 0, mem_write = 0, mem_wr = 0.
  - rdata = 0, all pN_rvalid = 0.
  - `starve` = 0, `rr` = 1, all tags invalid.
  - In-flight reads are dropped and never produce rvalid.
  - pN_ack is 0 while reset is high.

## Timing
- Request accepted in cycle t (ack high) → mem_* outputs valid in cycle t+1.
- Read accepted in cycle t → pN_rvalid and rdata valid in cycle t+2+READ_LAT (t+4 at the default).
  - Sampling: mem_read is sampled at the end of cycle t+1+READ_LAT.
- Throughput: one access per cycle, with back-to-back grants to any mix of ports. There is no read/write turnaround bubble (ZBT).
- Write with no ack: a requester whose req is high without ack must hold its fields; nothing is issued.
- Read ordering: returned reads stay in issue order across ports.
- Combinational paths: pN_ack depends combinationally on the pN_req inputs, `rr` and `starve` only. There is no path from mem_read to ack.
- Deassert timing: a requester may drop req in the cycle after ack, or keep it high for the next access.

## Test plan
- Single write:
  - Stimulus: after reset, p1_req=1, p1_we=1, p1_addr=19'h00010, p1_wdata=36'h123456789 for one cycle.
  - Response: p1_ack=1 that cycle. Next cycle mem_addr=19'h00010, mem_write=36'h123456789, mem_wr=1. The cycle after, mem_wr=0.
- Single read:
  - Stimulus: p0 read of addr 5 at cycle t; the bench model returns 36'hABCDE0005 on mem_read at t+3.
  - Response: p0_rvalid=1 and rdata=36'hABCDE0005 at t+4 only. p1_rvalid and p2_rvalid stay 0.
- Round-robin:
  - Stimulus: p1 and p2 requesting continuously, p0 idle, 6 cycles.
  - Response: acks go 1,2,1,2,1,2.
- Starvation guard:
  - Stimulus: STARVE_LIMIT=4, p0 and p1 requesting continuously.
  - Response: ack pattern 0,0,0,0,1 repeating; `starve` returns to 0 after each p1 ack.
- Mixed read ordering:
  - Stimulus: reads p0@1, p2@2, p1@3 in consecutive cycles.
  - Response: p0_rvalid, p2_rvalid, p1_rvalid on three consecutive cycles, each with its own data.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously with two reads in flight.
  - Response: mem_wr=0 and all rvalid=0 immediately. No rvalid after reset releases. The next low-port grant goes to port 1.
